// File: rtl/bp_pkg.sv
// Shared definitions for the two-bit branch predictor.
//   ctr_e       : 2-bit saturating counter states (SNT, WNT, WT, ST)
//   CTR_RST     : counter value loaded into every entry on reset
//   btb_entry_t : one BTB entry (valid, tag, target, ctr, uncond)
//   ctr_next    : saturating counter step given the resolved outcome
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam ctr_e CTR_RST = WNT;

  // Tags are kept in a fixed-width field so the entry struct does not depend
  // on the table size; the live tag bits are zero-extended into it.
  localparam int TAG_MAX_W = 30;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [31:0]          target;
    ctr_e                 ctr;
    logic                 uncond;
  } btb_entry_t;

  // Step the counter towards the observed outcome, saturating at both ends.
  function automatic ctr_e ctr_next(input ctr_e ctr, input logic taken);
    ctr_e nxt;
    nxt = ctr;
    case (ctr)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = ctr;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bp_two_bit_sat_ctr.sv
// bp_sat_ctr2: combinational next-state and prediction for one 2-bit
// saturating counter.
//   ctr_i        : current counter state
//   taken_i      : resolved outcome used to train the counter
//   force_st_i   : unconditional jump, pin the counter to strongly taken
//   ctr_o        : next counter state
//   pred_taken_o : prediction from the current state (upper counter bit)
module bp_sat_ctr2
  import bp_pkg::*;
(
  input  ctr_e ctr_i,
  input  logic taken_i,
  input  logic force_st_i,
  output ctr_e ctr_o,
  output logic pred_taken_o
);

  // Unconditional jumps are always taken, so their counter is forced to ST
  // regardless of the reported outcome.
  always_comb begin
    ctr_o = ctr_next(ctr_i, taken_i);
    if (force_st_i) begin
      ctr_o = ST;
    end
  end

  assign pred_taken_o = ctr_i[1];

endmodule

// File: rtl/bp_two_bit.sv
// bp_two_bit: direct-mapped BTB with a 2-bit saturating counter per entry.
// Lookup is combinational from the registered table; training updates land
// at the clock edge and are visible to lookup on the following cycle.
//   clk, rst    : clock and synchronous active-high reset
//   f_pc        : fetch PC to look up
//   pred_taken  : predicted taken
//   pred_hit    : valid entry with matching tag
//   pred_pc     : predicted next PC (target when taken, else f_pc+4)
//   upd_valid   : a resolved branch/jump is presented this cycle
//   upd_pc      : PC of the resolved instruction
//   upd_taken   : actual outcome from the branch unit
//   upd_uncond  : resolved instruction is jal/jalr
//   upd_target  : resolved target address
module bp_two_bit
  import bp_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = 30 - IDX_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] f_pc,
  output logic        pred_taken,
  output logic        pred_hit,
  output logic [31:0] pred_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic        upd_uncond,
  input  logic [31:0] upd_target
);

  btb_entry_t table_q [ENTRIES];
  btb_entry_t table_d [ENTRIES];

  logic [IDX_W-1:0]     f_idx;
  logic [IDX_W-1:0]     upd_idx;
  logic [TAG_W-1:0]     f_tag_raw;
  logic [TAG_W-1:0]     upd_tag_raw;
  logic [TAG_MAX_W-1:0] f_tag;
  logic [TAG_MAX_W-1:0] upd_tag;
  btb_entry_t           f_entry;
  btb_entry_t           upd_entry;
  logic                 upd_hit;
  logic                 f_ctr_taken;
  ctr_e                 upd_ctr_next;
  ctr_e                 unused_f_ctr_next;
  logic                 unused_upd_pred;
  logic                 unused_upd_pc_lsbs;

  // The two low PC bits select bytes within an instruction word and take no
  // part in indexing or tagging.
  assign unused_upd_pc_lsbs = ^upd_pc[1:0];

  assign f_idx       = f_pc[IDX_W+1:2];
  assign f_tag_raw   = f_pc[31:IDX_W+2];
  assign f_tag       = TAG_MAX_W'(f_tag_raw);
  assign upd_idx     = upd_pc[IDX_W+1:2];
  assign upd_tag_raw = upd_pc[31:IDX_W+2];
  assign upd_tag     = TAG_MAX_W'(upd_tag_raw);

  assign f_entry   = table_q[f_idx];
  assign upd_entry = table_q[upd_idx];
  assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);

  bp_sat_ctr2 u_lookup_ctr (
    .ctr_i        (f_entry.ctr),
    .taken_i      (1'b0),
    .force_st_i   (1'b0),
    .ctr_o        (unused_f_ctr_next),
    .pred_taken_o (f_ctr_taken)
  );

  bp_sat_ctr2 u_update_ctr (
    .ctr_i        (upd_entry.ctr),
    .taken_i      (upd_taken),
    .force_st_i   (upd_uncond),
    .ctr_o        (upd_ctr_next),
    .pred_taken_o (unused_upd_pred)
  );

  // Lookup reads the registered table only, so a same-cycle update to the
  // same index is not seen until the next cycle.
  assign pred_hit   = f_entry.valid && (f_entry.tag == f_tag);
  assign pred_taken = pred_hit && (f_entry.uncond || f_ctr_taken);
  assign pred_pc    = pred_taken ? f_entry.target : (f_pc + 32'd4);

  // Training: hits step the counter (target/uncond refreshed only on taken),
  // taken misses allocate over whatever was in the slot, not-taken misses
  // leave the table alone.
  always_comb begin
    table_d = table_q;
    if (upd_valid) begin
      if (upd_hit) begin
        table_d[upd_idx].ctr = upd_ctr_next;
        if (upd_taken) begin
          table_d[upd_idx].target = upd_target;
          table_d[upd_idx].uncond = upd_uncond;
        end
      end else if (upd_taken) begin
        table_d[upd_idx].valid  = 1'b1;
        table_d[upd_idx].tag    = upd_tag;
        table_d[upd_idx].target = upd_target;
        table_d[upd_idx].ctr    = upd_uncond ? ST : WT;
        table_d[upd_idx].uncond = upd_uncond;
      end
    end
  end

  // Reset wins over a concurrent update, which is simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i].valid  <= 1'b0;
        table_q[i].tag    <= '0;
        table_q[i].target <= '0;
        table_q[i].ctr    <= CTR_RST;
        table_q[i].uncond <= 1'b0;
      end
    end else begin
      table_q <= table_d;
    end
  end

endmodule

// File: tb/tb_bp_two_bit.sv
// Self-checking bench for bp_two_bit: directed walk through the predictor's
// training behaviour followed by randomized traffic, all compared against a
// table-of-integers reference model.
module tb_bp_two_bit;

  logic        clk;
  logic        rst;
  logic [31:0] f_pc;
  logic        pred_taken;
  logic        pred_hit;
  logic [31:0] pred_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_uncond;
  logic [31:0] upd_target;

  int checks = 0;
  int errors = 0;

  // Reference model: plain arrays indexed by (pc/4) mod 64, tag = pc/256.
  bit          modelValid  [64];
  int unsigned modelTag    [64];
  logic [31:0] modelTarget [64];
  int          modelCtr    [64];
  bit          modelUncond [64];
  bit          modelKnown = 0;

  bp_two_bit dut (
    .clk        (clk),
    .rst        (rst),
    .f_pc       (f_pc),
    .pred_taken (pred_taken),
    .pred_hit   (pred_hit),
    .pred_pc    (pred_pc),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_uncond (upd_uncond),
    .upd_target (upd_target)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int idxOf(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic int unsigned tagOf(input logic [31:0] pc);
    return int'(pc >> 8);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Drives one cycle of inputs, checks the combinational prediction against
  // the model mid-cycle, then advances the model across the clock edge.
  task automatic applyStimulus(input logic [31:0] fpc, input logic r,
                               input logic uv, input logic [31:0] upc,
                               input logic ut, input logic uu,
                               input logic [31:0] utgt,
                               output logic oHit, output logic oTaken,
                               output logic [31:0] oPc);
    int  i;
    bit  expHit;
    bit  expTaken;
    logic [31:0] expPc;
    f_pc       = fpc;
    rst        = r;
    upd_valid  = uv;
    upd_pc     = upc;
    upd_taken  = ut;
    upd_uncond = uu;
    upd_target = utgt;
    @(negedge clk);
    oHit   = pred_hit;
    oTaken = pred_taken;
    oPc    = pred_pc;
    if (modelKnown) begin
      i        = idxOf(fpc);
      expHit   = modelValid[i] && (modelTag[i] == tagOf(fpc));
      expTaken = expHit && (modelUncond[i] || modelCtr[i] >= 2);
      expPc    = expTaken ? modelTarget[i] : fpc + 32'd4;
      checkOutput("pred_hit",   {31'b0, pred_hit},   {31'b0, expHit});
      checkOutput("pred_taken", {31'b0, pred_taken}, {31'b0, expTaken});
      checkOutput("pred_pc",    pred_pc,             expPc);
    end
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < 64; k++) begin
        modelValid[k]  = 0;
        modelCtr[k]    = 1;
        modelUncond[k] = 0;
      end
      modelKnown = 1;
    end else if (uv && modelKnown) begin
      i = idxOf(upc);
      if (modelValid[i] && modelTag[i] == tagOf(upc)) begin
        if (uu)      modelCtr[i] = 3;
        else if (ut) modelCtr[i] = (modelCtr[i] == 3) ? 3 : modelCtr[i] + 1;
        else         modelCtr[i] = (modelCtr[i] == 0) ? 0 : modelCtr[i] - 1;
        if (ut) begin
          modelTarget[i] = utgt;
          modelUncond[i] = uu;
        end
      end else if (ut) begin
        modelValid[i]  = 1;
        modelTag[i]    = tagOf(upc);
        modelTarget[i] = utgt;
        modelUncond[i] = uu;
        modelCtr[i]    = uu ? 3 : 2;
      end
    end
    #1;
  endtask

  // Directed cycle with fixed expectations on top of the model comparison.
  task automatic directed(input string tag, input logic [31:0] fpc,
                          input logic r, input logic uv,
                          input logic [31:0] upc, input logic ut,
                          input logic uu, input logic [31:0] utgt,
                          input logic eHit, input logic eTaken,
                          input logic [31:0] ePc);
    logic h;
    logic t;
    logic [31:0] p;
    applyStimulus(fpc, r, uv, upc, ut, uu, utgt, h, t, p);
    checkOutput({tag, ".hit"},   {31'b0, h}, {31'b0, eHit});
    checkOutput({tag, ".taken"}, {31'b0, t}, {31'b0, eTaken});
    checkOutput({tag, ".pc"},    p,          ePc);
  endtask

  logic [31:0] tagPool [4];

  function automatic logic [31:0] randPc();
    logic [31:0] t;
    t = tagPool[$urandom_range(0, 3)];
    return (t << 8) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    logic h;
    logic t;
    logic [31:0] p;
    tagPool[0] = 32'h0;
    tagPool[1] = 32'h1;
    tagPool[2] = 32'h2;
    tagPool[3] = 32'hFFFFFF;

    $display("[TB] starting bp_two_bit bench");
    applyStimulus(32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, h, t, p);

    // Empty table, update and lookup of the same PC in the same cycle.
    directed("reset_miss",  32'h40, 0, 1, 32'h40, 1, 0, 32'h100, 1'b0, 1'b0, 32'h44);
    directed("alloc_wt",    32'h40, 0, 0, 32'h0,  0, 0, 32'h0,   1'b1, 1'b1, 32'h100);
    directed("nt1_from_wt", 32'h40, 0, 1, 32'h40, 0, 0, 32'h0,   1'b1, 1'b1, 32'h100);
    directed("nt2_from_wnt",32'h40, 0, 1, 32'h40, 0, 0, 32'h0,   1'b1, 1'b0, 32'h44);
    directed("nt3_at_snt",  32'h40, 0, 1, 32'h40, 0, 0, 32'h0,   1'b1, 1'b0, 32'h44);
    directed("t1_from_snt", 32'h40, 0, 1, 32'h40, 1, 0, 32'h100, 1'b1, 1'b0, 32'h44);
    directed("t2_from_wnt", 32'h40, 0, 1, 32'h40, 1, 0, 32'h100, 1'b1, 1'b0, 32'h44);
    directed("t3_from_wt",  32'h40, 0, 1, 32'h40, 1, 0, 32'h100, 1'b1, 1'b1, 32'h100);
    directed("t4_at_st",    32'h40, 0, 1, 32'h40, 1, 0, 32'h100, 1'b1, 1'b1, 32'h100);
    directed("nt_from_st",  32'h40, 0, 1, 32'h40, 0, 0, 32'h0,   1'b1, 1'b1, 32'h100);
    directed("still_wt",    32'h40, 0, 0, 32'h0,  0, 0, 32'h0,   1'b1, 1'b1, 32'h100);
    directed("alias_miss",  32'h140,0, 0, 32'h0,  0, 0, 32'h0,   1'b0, 1'b0, 32'h144);
    directed("alias_alloc", 32'h140,0, 1, 32'h140,1, 0, 32'h300, 1'b0, 1'b0, 32'h144);
    directed("alias_hit",   32'h140,0, 0, 32'h0,  0, 0, 32'h0,   1'b1, 1'b1, 32'h300);
    directed("evicted",     32'h40, 0, 0, 32'h0,  0, 0, 32'h0,   1'b0, 1'b0, 32'h44);
    directed("nt_miss",     32'hC0, 0, 1, 32'hC0, 0, 0, 32'h500, 1'b0, 1'b0, 32'hC4);
    directed("no_alloc",    32'hC0, 0, 0, 32'h0,  0, 0, 32'h0,   1'b0, 1'b0, 32'hC4);
    directed("uncond_upd",  32'h80, 0, 1, 32'h80, 1, 1, 32'h400, 1'b0, 1'b0, 32'h84);
    directed("uncond_hit",  32'h80, 0, 0, 32'h0,  0, 0, 32'h0,   1'b1, 1'b1, 32'h400);
    directed("pc_wrap",     32'hFFFFFFFC, 0, 0, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0, 32'h0);
    directed("rst_w_upd",   32'h80, 1, 1, 32'h40, 1, 0, 32'h500, 1'b1, 1'b1, 32'h400);
    directed("post_rst_80", 32'h80, 0, 0, 32'h0,  0, 0, 32'h0,   1'b0, 1'b0, 32'h84);
    directed("post_rst_40", 32'h40, 0, 0, 32'h0,  0, 0, 32'h0,   1'b0, 1'b0, 32'h44);
    directed("post_rst_140",32'h140,0, 0, 32'h0,  0, 0, 32'h0,   1'b0, 1'b0, 32'h144);

    // Random traffic over a small PC pool so hits, aliasing and saturation
    // all occur frequently; rare resets exercise the clear path mid-run.
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(randPc(), ($urandom_range(0, 299) == 0),
                    ($urandom_range(0, 3) != 0), randPc(),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                    $urandom, h, t, p);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
